// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding, word/byte geometry and byte-lane enable helper
package mem_pkg;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int LANES = WORD_W / BYTE_W;
  localparam int LANE_W = $clog2(LANES);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  function automatic logic [LANES-1:0] lane_en(input logic [LANE_W-1:0] lane);
    return LANES'(1) << lane;
  endfunction
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: load/store request channel (valid/ready) and response channel (valid/ready, rdata, err)
interface data_mem_responder_if import mem_pkg::*; #(parameter int ADDR_W = 8);
  logic req_valid, req_ready, req_write, req_byte;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [WORD_W-1:0] rsp_rdata;
  modport master(output req_valid, req_write, req_byte, req_addr, req_wdata, rsp_ready,
                 input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave(input req_valid, req_write, req_byte, req_addr, req_wdata, rsp_ready,
                output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/byte_en_ram.sv
// byte_en_ram: 2**AW x 32 word array, per-byte write enable, registered read of addr (old data on write)
module byte_en_ram import mem_pkg::*; #(parameter int AW = 6) (
  input  logic              clk,
  input  logic [AW-1:0]     addr,
  input  logic [LANES-1:0]  we,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (we[i]) mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: serves one latched load/store at a time after WAIT_CYCLES wait states (clk, rst_n, bus slave)
module data_mem_responder import mem_pkg::*; #(
  parameter int ADDR_W = 8,
  parameter int WAIT_CYCLES = 1
) (
  input logic clk,
  input logic rst_n,
  data_mem_responder_if.slave bus
);
  localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic wr_q, byte_q, err_q, commit;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q, ram_q;
  logic [BYTE_W-1:0] lane_byte;
  logic [LANES-1:0] we;
  always_comb begin
    state_n = state == IDLE   ? (bus.req_valid ? ACCESS : IDLE) :
              state == ACCESS ? (cnt == '0 ? RESP : ACCESS) :
                                (bus.rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.req_valid) begin
        wr_q <= bus.req_write;
        byte_q <= bus.req_byte;
        addr_q <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        err_q <= !bus.req_byte && bus.req_addr[1:0] != 2'b00;
        cnt <= CW'(WAIT_CYCLES);
      end else if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end
  assign commit = state == ACCESS && cnt == '0 && rst_n;
  assign we = commit && wr_q && !err_q ? (byte_q ? lane_en(addr_q[1:0]) : '1) : '0;
  byte_en_ram #(.AW(ADDR_W - 2)) ram (
    .clk,
    .addr(addr_q[ADDR_W-1:2]),
    .we,
    .wdata(byte_q ? {LANES{wdata_q[BYTE_W-1:0]}} : wdata_q),
    .rdata(ram_q)
  );
  assign lane_byte = ram_q[{addr_q[1:0], 3'b000} +: BYTE_W];
  assign bus.req_ready = rst_n && state == IDLE;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_err = state == RESP && err_q;
  assign bus.rsp_rdata = state == RESP && !wr_q && !err_q ?
                         (byte_q ? {{(WORD_W-BYTE_W){1'b0}}, lane_byte} : ram_q) : '0;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of data_mem_responder at WAIT_CYCLES 0, 1 and 3
module tb_data_mem_responder;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  int sel = 1;
  int checks = 0, errors = 0;
  logic req_valid = 0, req_write = 0, req_byte = 0, rsp_ready = 0;
  logic [7:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic ready, valid, err;
  logic [31:0] rdata;
  data_mem_responder_if #(.ADDR_W(8)) bus0(), bus1(), bus3();
  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0(.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) dut1(.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(3)) dut3(.clk(clk), .rst_n(rst_n), .bus(bus3.slave));
  assign {bus0.req_valid, bus0.req_write, bus0.req_byte, bus0.req_addr, bus0.req_wdata, bus0.rsp_ready} =
         {req_valid && sel == 0, req_write, req_byte, req_addr, req_wdata, rsp_ready};
  assign {bus1.req_valid, bus1.req_write, bus1.req_byte, bus1.req_addr, bus1.req_wdata, bus1.rsp_ready} =
         {req_valid && sel == 1, req_write, req_byte, req_addr, req_wdata, rsp_ready};
  assign {bus3.req_valid, bus3.req_write, bus3.req_byte, bus3.req_addr, bus3.req_wdata, bus3.rsp_ready} =
         {req_valid && sel == 3, req_write, req_byte, req_addr, req_wdata, rsp_ready};
  assign ready = sel == 0 ? bus0.req_ready : sel == 1 ? bus1.req_ready : bus3.req_ready;
  assign valid = sel == 0 ? bus0.rsp_valid : sel == 1 ? bus1.rsp_valid : bus3.rsp_valid;
  assign err = sel == 0 ? bus0.rsp_err : sel == 1 ? bus1.rsp_err : bus3.rsp_err;
  assign rdata = sel == 0 ? bus0.rsp_rdata : sel == 1 ? bus1.rsp_rdata : bus3.rsp_rdata;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (wc=%0d): got %h, expected %h", tag, sel, got, exp);
    end
  endtask
  task automatic send(input logic w, input logic b, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    {req_write, req_byte, req_addr, req_wdata, req_valid} = {w, b, a, d, 1'b1};
    check("req_ready_idle", 32'(ready), 1);
    @(posedge clk);
    #1;
    {req_write, req_byte, req_addr, req_wdata, req_valid} = {~w, ~b, ~a, ~d, 1'b0};
  endtask
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (lat <= 50) begin
      @(negedge clk);
      if (valid) break;
      lat++;
    end
  endtask
  task automatic ack();
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    @(negedge clk);
    check("req_ready_after_ack", 32'(ready), 1);
    check("rdata_cleared", rdata, 0);
  endtask
  task automatic xact(input int s, input logic w, input logic b, input logic [7:0] a, input logic [31:0] d,
                      input logic [31:0] exp_d, input logic exp_e, input int hold);
    int lat;
    sel = s;
    send(w, b, a, d);
    wait_rsp(lat);
    check("latency", 32'(lat), 32'(s + 1));
    check("rdata", rdata, exp_d);
    check("err", 32'(err), 32'(exp_e));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(valid), 1);
      check("bp_rdata", rdata, exp_d);
      check("bp_req_ready", 32'(ready), 0);
    end
    ack();
  endtask
  initial begin
    logic seen;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(valid), 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", 32'(err), 0);
    check("rst_req_ready", 32'(ready), 0);
    rst_n = 1;
    @(negedge clk);
    check("idle_req_ready", 32'(ready), 1);
    xact(1, 1, 0, 8'h10, 32'hDEADBEEF, 32'h0, 0, 0);
    xact(1, 0, 0, 8'h10, 32'h0, 32'hDEADBEEF, 0, 0);
    xact(1, 1, 0, 8'h20, 32'h11223344, 32'h0, 0, 0);
    xact(1, 1, 1, 8'h22, 32'h123456AA, 32'h0, 0, 0);
    xact(1, 0, 0, 8'h20, 32'h0, 32'h11AA3344, 0, 0);
    xact(1, 0, 1, 8'h23, 32'h0, 32'h00000011, 0, 0);
    xact(1, 1, 0, 8'h21, 32'hFFFFFFFF, 32'h0, 1, 0);
    xact(1, 0, 0, 8'h20, 32'h0, 32'h11AA3344, 0, 5);
    xact(3, 1, 0, 8'h30, 32'hCAFEF00D, 32'h0, 0, 0);
    send(1, 0, 8'h30, 32'h00000055);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    check("midrst_valid", 32'(valid), 0);
    check("midrst_rdata", rdata, 0);
    check("midrst_err", 32'(err), 0);
    check("midrst_req_ready", 32'(ready), 0);
    rst_n = 1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      seen |= valid;
    end
    check("midrst_no_rsp", 32'(seen), 0);
    xact(3, 0, 0, 8'h30, 32'h0, 32'hCAFEF00D, 0, 0);
    xact(0, 1, 0, 8'h00, 32'hA5A5A5A5, 32'h0, 0, 0);
    xact(0, 1, 0, 8'hFC, 32'h12345678, 32'h0, 0, 0);
    xact(0, 0, 0, 8'hFC, 32'h0, 32'h12345678, 0, 0);
    xact(0, 0, 0, 8'h00, 32'h0, 32'hA5A5A5A5, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the CPU's data-memory load/store interface. The control unit issues one load or store request at a time: byte address, word/byte select and, for stores, write data. This block serves the request from a private word array and returns a single response: read data for loads, a completion acknowledge for stores. Both directions use a valid/ready handshake, and a programmable wait-state counter models slower memory.

## Interface
Parameters:
- ADDR_W, 8, byte-address width; memory depth is 2**(ADDR_W-2) 32-bit words
- WAIT_CYCLES, 1, extra cycles between request acceptance and memory commit; 0 is legal

Ports:
- clk  input  1  single clock; everything on rising edge
- rst_n  input  1  synchronous, active-low reset; one clock, reset is synchronous and active-low
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_write  input  1  1 = store, 0 = load (ARM L bit inverted)
- req_byte  input  1  1 = byte access, 0 = word access (ARM B bit)
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data; byte stores use bits [7:0]
- rsp_valid  output  1  response present
- rsp_ready  input  1  initiator accepts response
- rsp_rdata  output  32  load data; 0 for stores and errors
- rsp_err  output  1  misaligned word access

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE**
  - req_ready = 1.
  - On req_valid && req_ready, latch write/byte/addr/wdata, load cnt = WAIT_CYCLES, go to ACCESS.
- **ACCESS**
  - req_ready = 0.
  - If cnt != 0: cnt decrements.
  - If cnt == 0: perform the access at this edge and go to RESP.
- **RESP**
  - rsp_valid = 1, and rsp_rdata/rsp_err hold stable.
  - On rsp_valid && rsp_ready, go to IDLE.
- Word index = addr[ADDR_W-1:2]; lane = addr[1:0]; little-endian.
- Word load: rdata = mem[index].
- Word store: mem[index] = wdata, all four byte enables.
- Byte load: rdata = {24'b0, mem[index] byte at lane} (zero-extended).
- Byte store: only byte enable `lane` set; that lane is written with wdata[7:0], other lanes untouched.
- Misaligned word access (req_byte = 0, addr[1:0] != 0):
  - no memory write;
  - rsp_err = 1, rsp_rdata = 0;
  - still passes through ACCESS with the same latency.
- The latched request is used for the whole transaction; req_* changes after acceptance are ignored.
- Memory contents are not cleared by reset; bench initialises by stores.

## Timing
- Reset values (rst_n low at an edge): state IDLE, cnt 0, rsp_valid 0, rsp_rdata 0, rsp_err 0.
- req_ready is 0 in any cycle where rst_n is low, and 1 in IDLE otherwise.
- Latency: rsp_valid rises WAIT_CYCLES+1 edges after the acceptance edge.
  - WAIT_CYCLES = 0: rsp_valid is high in the cycle after the acceptance cycle... i.e. one edge later.
- Store commit happens at the edge that enters RESP. A load issued after the store's response always sees the new data.
- req_ready is deasserted from the acceptance edge until the edge after the response handshake.
  - Minimum request spacing is WAIT_CYCLES+3 cycles.
  - No same-cycle response-accept/request-accept overlap.
- rsp_ready held low: RESP persists indefinitely, outputs stable.
- rsp_ready high before rsp_valid: no effect.
- rsp_rdata/rsp_err are cleared to 0 on the handshake edge.
- Reset mid-transaction: abandon the transaction.
  - If reset arrives before the commit edge, the store is not written.
  - No response is produced.
  - The transaction state returns to IDLE at that edge.

## Structure
- Shared package mem_pkg:
  - state enum {IDLE, ACCESS, RESP};
  - WORD_W = 32;
  - byte-lane helper constants.
- The control unit imports the same package for request field widths.
- Sub-module byte_en_ram: 2**(ADDR_W-2) × 32, 4-bit byte write enable, synchronous read of the same address in the same edge.
  - Read returns old data on a simultaneous write; irrelevant here, since loads never write.
- The responder owns the FSM, counter, lane select/extension and error check.

## Test plan
- **Word store then load** (WAIT_CYCLES = 1):
  - store 0xDEADBEEF @0x10, ack with rsp_err = 0 and rsp_rdata = 0;
  - load @0x10 → rdata 0xDEADBEEF, with rsp_valid exactly 2 edges after acceptance.
- **Byte lanes**:
  - word store 0x11223344 @0x20;
  - byte store 0xAA @0x22;
  - word load @0x20 → 0x11AA3344;
  - byte load @0x23 → 0x00000011.
- **Misaligned word**:
  - store 0xFFFFFFFF @0x21 → rsp_err = 1, rdata 0;
  - word load @0x20 is unchanged at 0x11AA3344.
- **Backpressure**:
  - hold rsp_ready = 0 for 5 cycles → rsp_valid and rdata stable, req_ready = 0 throughout;
  - release → IDLE and req_ready = 1 one edge later.
- **Reset mid-store**: WAIT_CYCLES = 3, store 0x55 @0x30, assert rst_n low one cycle after acceptance.
  - No response is produced, and all outputs take reset values.
  - A subsequent load @0x30 returns the prior contents.
- **WAIT_CYCLES = 0, address wrap**:
  - store 0x12345678 @0xFC and load it back → latency 1 edge, data 0x12345678;
  - load @0x00 is unaffected.
